// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing a single uart_tx serializer among NUM_REQ byte producers.
// Define UART_ARB_TAG_EN to precede every granted byte with a tag byte {4'hA, 1'b0, id[2:0]}.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_send,
    input  logic                         tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         arb_busy,
    output logic                         fault
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ID_W:0]    NUM_REQ_X = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [2:0] {
        IDLE, TAG_ISSUE, TAG_WAIT_BUSY, TAG_WAIT_DONE, ISSUE, WAIT_BUSY, WAIT_DONE
    } state_t;

    logic [DATA_BITS-1:0] hold;

    function automatic logic [DATA_BITS-1:0] tag_byte(input logic [ID_W-1:0] id);
        tag_byte = {4'hA, 1'b0, 3'(id)};
    endfunction
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
`endif

    state_t               state;
    logic [ID_W-1:0]      ptr;
    logic [CNT_W-1:0]     cnt;
    logic                 found;
    logic [ID_W-1:0]      winner;
    logic [ID_W:0]        idx;
    logic [DATA_BITS-1:0] win_byte;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [ID_W-1:0]      next_ptr;

    // Search ptr, ptr+1, ... wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W + 1)'(k);
            if (idx >= NUM_REQ_X) idx = idx - NUM_REQ_X;
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) win_byte = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    assign win_onehot = NUM_REQ'(1) << winner;
    assign next_ptr   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            req_ready <= '0;
            tx_data   <= '0;
            tx_send   <= 1'b0;
            grant_id  <= '0;
            arb_busy  <= 1'b0;
            fault     <= 1'b0;
`ifdef UART_ARB_TAG_EN
            hold      <= '0;
`endif
        end else begin
            req_ready <= '0;
            tx_send   <= 1'b0;
            case (state)
                IDLE: begin
                    // Hold off while the serializer is still draining a previous frame.
                    if (!tx_busy && found) begin
                        grant_id  <= winner;
                        req_ready <= win_onehot;
                        arb_busy  <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        tx_data   <= tag_byte(winner);
                        hold      <= win_byte;
                        state     <= TAG_ISSUE;
`else
                        tx_data   <= win_byte;
                        state     <= ISSUE;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                TAG_ISSUE: begin
                    tx_send <= 1'b1;
                    ptr     <= next_ptr;
                    cnt     <= '0;
                    state   <= TAG_WAIT_BUSY;
                end
                TAG_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= TAG_WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        fault    <= 1'b1;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TAG_WAIT_DONE: begin
                    if (!tx_busy) begin
                        tx_data <= hold;
                        state   <= ISSUE;
                    end
                end
`endif
                ISSUE: begin
                    tx_send <= 1'b1;
                    ptr     <= next_ptr;
                    cnt     <= '0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A serializer that never acknowledges costs this byte, not the whole arbiter.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        fault    <= 1'b1;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: behavioural uart_tx model on the serializer side and a
// scoreboard of expected (requester, byte) pairs popped at every tx_send strobe.
module tb_uart_tx_arbiter;
    localparam int CPB = 4;
`ifdef UART_ARB_TAG_EN
    localparam int NFRAMES = 2;
`else
    localparam int NFRAMES = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_valid = '0;
    logic [7:0] bytes_in [4];
    logic [31:0] req_data;
    logic [3:0] req_ready;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic [1:0] grant_id;
    logic       arb_busy;
    logic       fault;

    logic       stub_dead = 1'b0;
    logic       busy_m;
    logic       line;
    logic [8:0] sh;
    int         bitcnt;
    int         clkcnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] b;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    assign req_data = {bytes_in[3], bytes_in[2], bytes_in[1], bytes_in[0]};
    assign tx_busy  = stub_dead ? 1'b0 : busy_m;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .BUSY_TIMEOUT(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy),
        .fault     (fault)
    );

    // Serializer model: start bit, 8 data bits LSB first, stop bit, CPB clocks per bit.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_m <= 1'b0;
            line   <= 1'b1;
            sh     <= '1;
            bitcnt <= 0;
            clkcnt <= 0;
        end else if (!busy_m) begin
            if (tx_send && !stub_dead) begin
                sh     <= {1'b1, tx_data};
                busy_m <= 1'b1;
                line   <= 1'b0;
                bitcnt <= 0;
                clkcnt <= 0;
            end
        end else if (clkcnt == CPB - 1) begin
            clkcnt <= 0;
            if (bitcnt == 9) begin
                busy_m <= 1'b0;
                line   <= 1'b1;
            end else begin
                line   <= sh[0];
                sh     <= {1'b1, sh[8:1]};
                bitcnt <= bitcnt + 1;
            end
        end else begin
            clkcnt <= clkcnt + 1;
        end
    end

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && tx_send) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: tx_send with tx_data=%h grant_id=%0d, required no send", tx_data, grant_id);
            end else begin
                e = sb.pop_front();
                if (tx_data !== e.b || grant_id !== e.id) begin
                    errors++;
                    $display("FAIL sb_byte: got tx_data=%h grant_id=%0d, required tx_data=%h grant_id=%0d",
                             tx_data, grant_id, e.b, e.id);
                end
            end
        end
        if (!reset && req_ready != 4'b0000) begin
            checks++;
            if (!$onehot(req_ready)) begin
                errors++;
                $display("FAIL ready_onehot: got req_ready=%b, required one-hot", req_ready);
            end
        end
    end

    task automatic push_grant(input logic [1:0] id, input logic [7:0] b);
        exp_t e;
        e.id = id;
`ifdef UART_ARB_TAG_EN
        e.b = {4'hA, 2'b00, id};
        sb.push_back(e);
`endif
        e.b = b;
        sb.push_back(e);
    endtask

    task automatic push_first(input logic [1:0] id, input logic [7:0] b);
        exp_t e;
        e.id = id;
`ifdef UART_ARB_TAG_EN
        e.b = {4'hA, 2'b00, id};
`else
        e.b = b;
`endif
        sb.push_back(e);
    endtask

    task automatic wait_ready(output logic [3:0] r);
        r = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if (req_ready != 4'b0000) begin
                r = req_ready;
                break;
            end
        end
    endtask

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if (!arb_busy && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_req(input logic [1:0] id, input logic [7:0] b, input bit full, output bit ok);
        logic [3:0] r;
        if (full) push_grant(id, b);
        else push_first(id, b);
        bytes_in[id]  = b;
        req_valid[id] = 1'b1;
        wait_ready(r);
        req_valid[id] = 1'b0;
        ok = (r == (4'b0001 << id));
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({req_ready, tx_data, tx_send, grant_id, arb_busy, fault} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", {req_ready, tx_data, tx_send, grant_id, arb_busy, fault});
        end
        checks++;
        if (line !== 1'b1) begin
            errors++;
            $display("FAIL reset_line: got %b, required 1", line);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        logic prev;
        int   falls;
        push_grant(2'd0, 8'h55);
        bytes_in[0]  = 8'h55;
        req_valid[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 4'b0001 || tx_send !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got req_ready=%b tx_send=%b, required 0001/0", req_ready, tx_send);
        end
        req_valid[0] = 1'b0;
        @(negedge clock);
        checks++;
        if (tx_send !== 1'b1 || arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got tx_send=%b arb_busy=%b, required 1/1", tx_send, arb_busy);
        end
        prev  = tx_busy;
        falls = 0;
        for (int c = 0; c < 2000 && falls < NFRAMES; c++) begin
            @(negedge clock);
            if (prev && !tx_busy) falls++;
            prev = tx_busy;
        end
        checks++;
        if (falls != NFRAMES || arb_busy !== 1'b1 || line !== 1'b1) begin
            errors++;
            $display("FAIL single_done: got falls=%0d arb_busy=%b line=%b, required %0d/1/1", falls, arb_busy, line, NFRAMES);
        end
        @(negedge clock);
        checks++;
        if (arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_arb_busy_fall: got %b, required 0", arb_busy);
        end
    endtask

    task automatic test_pointer_wrap();
        bit ok;
        bit q;
        logic [3:0] r;
        drive_req(2'd3, 8'hC3, 1'b1, ok);
        wait_quiet(q);
        checks++;
        if (!ok || !q) begin
            errors++;
            $display("FAIL wrap_first: got ready_ok=%b quiet=%b, required 1/1", ok, q);
        end
        push_grant(2'd0, 8'h0A);
        push_grant(2'd3, 8'h3B);
        bytes_in[0] = 8'h0A;
        bytes_in[3] = 8'h3B;
        req_valid   = 4'b1001;
        wait_ready(r);
        req_valid[0] = 1'b0;
        checks++;
        if (r !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_to_zero: got req_ready=%b, required 0001", r);
        end
        wait_ready(r);
        req_valid[3] = 1'b0;
        checks++;
        if (r !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_then_three: got req_ready=%b, required 1000", r);
        end
        wait_quiet(q);
    endtask

    task automatic test_fairness();
        int cnt [4];
        int n;
        bit q;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        n = 0;
        bytes_in[0] = 8'h10;
        bytes_in[1] = 8'h21;
        bytes_in[2] = 8'h32;
        bytes_in[3] = 8'h43;
        for (int rep = 0; rep < 2; rep++) begin
            push_grant(2'd0, 8'h10);
            push_grant(2'd1, 8'h21);
            push_grant(2'd2, 8'h32);
            push_grant(2'd3, 8'h43);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            if (req_ready != 4'b0000) begin
                n++;
                for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
                if (n == 4) begin
                    checks++;
                    if (cnt[0] != 1 || cnt[1] != 1 || cnt[2] != 1 || cnt[3] != 1) begin
                        errors++;
                        $display("FAIL fair_first_round: got %0d/%0d/%0d/%0d, required 1/1/1/1", cnt[0], cnt[1], cnt[2], cnt[3]);
                    end
                end
                if (n == 8) begin
                    req_valid = 4'b0000;
                    break;
                end
            end
        end
        req_valid = 4'b0000;
        wait_quiet(q);
        checks++;
        if (n != 8 || cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2 || cnt[3] != 2 || !q || sb.size() != 0) begin
            errors++;
            $display("FAIL fair_total: got n=%0d cnt=%0d/%0d/%0d/%0d pending=%0d, required 8 2/2/2/2 0",
                     n, cnt[0], cnt[1], cnt[2], cnt[3], sb.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok1;
        bit ok2;
        bit q;
        drive_req(2'd2, 8'h5A, 1'b1, ok1);
        drive_req(2'd2, 8'hA5, 1'b1, ok2);
        wait_quiet(q);
        checks++;
        if (!ok1 || !ok2 || !q || sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: got ok=%b%b quiet=%b pending=%0d, required 11/1/0", ok1, ok2, q, sb.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        bit q;
        stub_dead = 1'b1;
        drive_req(2'd1, 8'hAA, 1'b0, ok);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (tx_send) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!ok || !seen) begin
            errors++;
            $display("FAIL timeout_send: got ready_ok=%b send_seen=%b, required 1/1", ok, seen);
        end
        repeat (15) @(posedge clock);
        @(negedge clock);
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got fault=%b after 15 cycles, required 0", fault);
        end
        @(negedge clock);
        checks++;
        if (fault !== 1'b1 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: got fault=%b arb_busy=%b after 16 cycles, required 1/0", fault, arb_busy);
        end
        stub_dead = 1'b0;
        drive_req(2'd2, 8'h5C, 1'b1, ok);
        wait_quiet(q);
        checks++;
        if (!ok || !q || fault !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL timeout_recover: got ok=%b quiet=%b fault=%b pending=%0d, required 1/1/1/0", ok, q, fault, sb.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit hit;
        bit q;
        drive_req(2'd1, 8'hF0, 1'b1, ok);
        hit = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if (busy_m && bitcnt == 4) begin
                hit = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        checks++;
        if (!ok || !hit || {req_ready, tx_data, tx_send, grant_id, arb_busy, fault} !== 17'd0 || line !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got ok=%b hit=%b outputs=%h line=%b, required 1/1/0/1",
                     ok, hit, {req_ready, tx_data, tx_send, grant_id, arb_busy, fault}, line);
        end
        reset = 1'b0;
        @(negedge clock);
        drive_req(2'd1, 8'h3C, 1'b1, ok);
        wait_quiet(q);
        checks++;
        if (!ok || !q || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_resume: got ok=%b quiet=%b pending=%0d, required 1/1/0", ok, q, sb.size());
        end
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic test_tag();
        bit ok;
        int extra;
        extra = 0;
        drive_req(2'd2, 8'h7E, 1'b1, ok);
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if (req_ready != 4'b0000) extra++;
            if (!arb_busy && !tx_busy) break;
        end
        checks++;
        if (!ok || extra != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL tag_pair: got ok=%b extra_ready=%0d pending=%0d, required 1/0/0", ok, extra, sb.size());
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) bytes_in[i] = 8'h00;
        test_reset();
        test_single();
        test_pointer_wrap();
        test_fairness();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
`ifdef UART_ARB_TAG_EN
        test_tag();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
